// File: rtl/spgd_pkg.sv
// Shared definitions for the SPGD acquisition path: state codes, ADC code limits,
// default sizing and a small helper for clamping the averaging exponent.
package spgd_pkg;

  localparam int DATA_WIDTH_DEF   = 14;
  localparam int COUNT_WIDTH_DEF  = 15;
  localparam int MAX_AVG_LOG2_DEF = 10;

  // Acquisition state codes, also exported on ACQ_STATE for GPIO readback
  localparam logic [1:0] ACQ_IDLE   = 2'b00;
  localparam logic [1:0] ACQ_SETTLE = 2'b01;
  localparam logic [1:0] ACQ_ACCUM  = 2'b10;
  localparam logic [1:0] ACQ_DONE   = 2'b11;

  // Full-scale codes of the default-width two's complement ADC
  localparam logic signed [DATA_WIDTH_DEF-1:0] ADC_MIN_CODE = {1'b1, {(DATA_WIDTH_DEF-1){1'b0}}};
  localparam logic signed [DATA_WIDTH_DEF-1:0] ADC_MAX_CODE = {1'b0, {(DATA_WIDTH_DEF-1){1'b1}}};

  // Requested window exponents beyond what the accumulator can hold are clamped
  function automatic logic [3:0] clamp_avg_log2(input logic [3:0] avg_log2,
                                                input logic [3:0] max_log2);
    return (avg_log2 > max_log2) ? max_log2 : avg_log2;
  endfunction

endpackage

// File: rtl/spgd_acq_accum.sv
// Window accumulator: sums sign-extended samples, flags full-scale codes and
// produces the floor-rounded mean on the final sample of a window.
module spgd_acq_accum #(
  parameter int DATA_WIDTH   = 14,
  parameter int MAX_AVG_LOG2 = 10,
  parameter int ACC_WIDTH    = DATA_WIDTH + MAX_AVG_LOG2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         add,
  input  logic                         finish,
  input  logic [3:0]                   shift,
  input  logic signed [DATA_WIDTH-1:0] sample,
  output logic signed [DATA_WIDTH-1:0] j_out,
  output logic                         clip
);

  localparam logic signed [DATA_WIDTH-1:0] MIN_CODE = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [DATA_WIDTH-1:0] MAX_CODE = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  logic signed [ACC_WIDTH-1:0] acc_reg;
  logic signed [ACC_WIDTH-1:0] sample_ext;
  logic signed [ACC_WIDTH-1:0] acc_sum;
  logic                        is_extreme;

  assign sample_ext = ACC_WIDTH'(sample);
  assign acc_sum    = acc_reg + sample_ext;
  assign is_extreme = (sample == MIN_CODE) || (sample == MAX_CODE);

  // Accumulate while enabled; the mean uses the sum including the current sample
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_reg <= '0;
      j_out   <= '0;
      clip    <= 1'b0;
    end else if (clear) begin
      acc_reg <= '0;
      clip    <= 1'b0;
    end else if (add) begin
      acc_reg <= acc_sum;
      if (is_extreme) begin
        clip <= 1'b1;
      end
      if (finish) begin
        j_out <= DATA_WIDTH'(acc_sum >>> shift);
      end
    end
  end

endmodule

// File: rtl/spgd_adc_acq_ctrl.sv
// Acquisition controller: on each ADC_EN window waits the settle time, averages
// 2^K samples through spgd_acq_accum and holds ADC_DONE until ADC_EN falls.
module spgd_adc_acq_ctrl
  import spgd_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int COUNT_WIDTH  = COUNT_WIDTH_DEF,
  parameter int MAX_AVG_LOG2 = MAX_AVG_LOG2_DEF,
  parameter int ACC_WIDTH    = DATA_WIDTH + MAX_AVG_LOG2
) (
  input  logic                          ADC_CLK,
  input  logic                          RST_N,
  input  logic                          ADC_EN,
  input  logic signed [DATA_WIDTH-1:0]  ADC_DATA,
  input  logic [COUNT_WIDTH-1:0]        SETTLE_CYCLES,
  input  logic [3:0]                    AVG_LOG2,
  output logic                          ADC_DONE,
  output logic signed [DATA_WIDTH-1:0]  J_OUT,
  output logic                          J_VALID,
  output logic                          ADC_CLIP,
  output logic [1:0]                    ACQ_STATE
);

  localparam int         CNT_W = MAX_AVG_LOG2 + 1;
  localparam logic [3:0] MAX_K = 4'(MAX_AVG_LOG2);

  logic [1:0]             state_reg;
  logic [COUNT_WIDTH-1:0] settle_cnt_reg;
  logic [CNT_W-1:0]       sample_cnt_reg;
  logic [3:0]             k_reg;
  logic                   done_reg;
  logic                   valid_reg;

  logic [CNT_W-1:0]       n_last;
  logic                   last_sample;
  logic                   acc_clear;
  logic                   acc_add;

  // Index of the final sample in the window (N-1)
  assign n_last      = (CNT_W'(1) << k_reg) - CNT_W'(1);
  assign last_sample = (sample_cnt_reg == n_last);
  assign acc_clear   = (state_reg == ACQ_IDLE) && ADC_EN;
  assign acc_add     = (state_reg == ACQ_ACCUM) && ADC_EN;

  // Window sequencing: IDLE -> SETTLE (S cycles) -> ACCUM (N cycles) -> DONE
  always_ff @(posedge ADC_CLK) begin
    if (!RST_N) begin
      state_reg      <= ACQ_IDLE;
      settle_cnt_reg <= '0;
      sample_cnt_reg <= '0;
      k_reg          <= '0;
      done_reg       <= 1'b0;
      valid_reg      <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      case (state_reg)
        ACQ_IDLE: begin
          if (ADC_EN) begin
            settle_cnt_reg <= SETTLE_CYCLES;
            k_reg          <= clamp_avg_log2(AVG_LOG2, MAX_K);
            sample_cnt_reg <= '0;
            state_reg      <= (SETTLE_CYCLES != '0) ? ACQ_SETTLE : ACQ_ACCUM;
          end
        end
        ACQ_SETTLE: begin
          if (!ADC_EN) begin
            state_reg <= ACQ_IDLE;
          end else if (settle_cnt_reg <= COUNT_WIDTH'(1)) begin
            state_reg <= ACQ_ACCUM;
          end else begin
            settle_cnt_reg <= settle_cnt_reg - COUNT_WIDTH'(1);
          end
        end
        ACQ_ACCUM: begin
          if (!ADC_EN) begin
            state_reg <= ACQ_IDLE;
          end else if (last_sample) begin
            done_reg  <= 1'b1;
            valid_reg <= 1'b1;
            state_reg <= ACQ_DONE;
          end else begin
            sample_cnt_reg <= sample_cnt_reg + CNT_W'(1);
          end
        end
        default: begin
          if (!ADC_EN) begin
            done_reg  <= 1'b0;
            state_reg <= ACQ_IDLE;
          end
        end
      endcase
    end
  end

  spgd_acq_accum #(
    .DATA_WIDTH   (DATA_WIDTH),
    .MAX_AVG_LOG2 (MAX_AVG_LOG2),
    .ACC_WIDTH    (ACC_WIDTH)
  ) u_accum (
    .clk    (ADC_CLK),
    .rst_n  (RST_N),
    .clear  (acc_clear),
    .add    (acc_add),
    .finish (last_sample),
    .shift  (k_reg),
    .sample (ADC_DATA),
    .j_out  (J_OUT),
    .clip   (ADC_CLIP)
  );

  assign ADC_DONE  = done_reg;
  assign J_VALID   = valid_reg;
  assign ACQ_STATE = state_reg;

endmodule

// File: tb/tb_spgd_adc_acq_ctrl.sv
// Self-checking bench for spgd_adc_acq_ctrl: directed windows with random
// sample data, checked cycle by cycle against a window-level mean/clip model.
module tb_spgd_adc_acq_ctrl;
  import spgd_pkg::*;

  logic               ADC_CLK = 1'b0;
  logic               RST_N;
  logic               ADC_EN;
  logic signed [13:0] ADC_DATA;
  logic [14:0]        SETTLE_CYCLES;
  logic [3:0]         AVG_LOG2;
  logic               ADC_DONE;
  logic signed [13:0] J_OUT;
  logic               J_VALID;
  logic               ADC_CLIP;
  logic [1:0]         ACQ_STATE;

  int n_checks = 0;
  int n_fail   = 0;
  int prev_j   = 0;
  int prev_clip = 0;
  int tbl[4] = '{-3, -3, -2, -2};

  spgd_adc_acq_ctrl dut (
    .ADC_CLK       (ADC_CLK),
    .RST_N         (RST_N),
    .ADC_EN        (ADC_EN),
    .ADC_DATA      (ADC_DATA),
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .AVG_LOG2      (AVG_LOG2),
    .ADC_DONE      (ADC_DONE),
    .J_OUT         (J_OUT),
    .J_VALID       (J_VALID),
    .ADC_CLIP      (ADC_CLIP),
    .ACQ_STATE     (ACQ_STATE)
  );

  always #5 ADC_CLK = ~ADC_CLK;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One active edge, then settle to the falling edge for sampling/driving
  task automatic tick;
    @(posedge ADC_CLK);
    @(negedge ADC_CLK);
  endtask

  // Mean of n samples rounded toward minus infinity
  function automatic int floor_mean(input int sum, input int n);
    int q;
    q = sum / n;
    if ((sum % n) != 0 && sum < 0) q = q - 1;
    return q;
  endfunction

  function automatic int rand_in_range();
    return int'($urandom_range(16381, 0)) - 8191;
  endfunction

  function automatic int rand_any();
    return int'($urandom_range(16383, 0)) - 8192;
  endfunction

  // Run one window. mode: 0 random in-range, 1 constant 100, 2 table, 3 random
  // with one full-scale sample. abort_edge / cfg_edge < 0 disable those events.
  task automatic run_window(input int s, input int avg, input int mode,
                            input int abort_edge, input int cfg_edge);
    int k, n, total, sum, idx, v, expj;
    int clip_exp;
    bit aborted;
    logic [1:0] st_exp;
    k = (avg > MAX_AVG_LOG2_DEF) ? MAX_AVG_LOG2_DEF : avg;
    n = 1 << k;
    total = s + n;
    sum = 0;
    clip_exp = 0;
    aborted = 0;
    ADC_EN = 1'b1;
    SETTLE_CYCLES = 15'(s);
    AVG_LOG2 = 4'(avg);
    ADC_DATA = 14'(rand_any());
    tick;
    check("start_state", ACQ_STATE, (s > 0) ? ACQ_SETTLE : ACQ_ACCUM);
    check("start_done", ADC_DONE, 0);
    for (int e = 1; e <= total; e++) begin
      if (e > s) begin
        idx = e - s - 1;
        case (mode)
          1:       v = 100;
          2:       v = tbl[idx];
          3:       v = (idx == n / 2) ? 8191 : rand_in_range();
          default: v = rand_in_range();
        endcase
        sum += v;
        if (v == -8192 || v == 8191) clip_exp = 1;
      end else begin
        v = rand_any();
      end
      ADC_DATA = 14'(v);
      if (e == cfg_edge) begin
        SETTLE_CYCLES = 15'd50;
        AVG_LOG2 = 4'd5;
      end
      if (e == abort_edge) ADC_EN = 1'b0;
      tick;
      if (e == abort_edge) begin
        check("abort_state", ACQ_STATE, ACQ_IDLE);
        check("abort_valid", J_VALID, 0);
        check("abort_done", ADC_DONE, 0);
        check("abort_j", J_OUT, prev_j);
        $display("window s=%0d k=%0d aborted at edge %0d, j held %0d", s, k, e, J_OUT);
        aborted = 1;
        break;
      end
      st_exp = (e < s) ? ACQ_SETTLE : (e < total) ? ACQ_ACCUM : ACQ_DONE;
      check("state", ACQ_STATE, st_exp);
      check("done", ADC_DONE, (e == total) ? 1 : 0);
      check("valid", J_VALID, (e == total) ? 1 : 0);
    end
    if (!aborted) begin
      expj = floor_mean(sum, n);
      check("j_out", J_OUT, expj);
      check("clip", ADC_CLIP, clip_exp);
      tick;
      check("hold_done", ADC_DONE, 1);
      check("hold_valid", J_VALID, 0);
      check("hold_j", J_OUT, expj);
      ADC_EN = 1'b0;
      tick;
      check("release_state", ACQ_STATE, ACQ_IDLE);
      check("release_done", ADC_DONE, 0);
      check("release_j", J_OUT, expj);
      check("release_clip", ADC_CLIP, clip_exp);
      prev_j = expj;
      prev_clip = clip_exp;
      $display("window s=%0d k=%0d j=%0d clip=%0d", s, k, J_OUT, ADC_CLIP);
    end
  endtask

  initial begin
    RST_N = 1'b0;
    ADC_EN = 1'b0;
    ADC_DATA = '0;
    SETTLE_CYCLES = '0;
    AVG_LOG2 = '0;
    repeat (2) tick;
    check("rst_state", ACQ_STATE, ACQ_IDLE);
    check("rst_done", ADC_DONE, 0);
    check("rst_valid", J_VALID, 0);
    check("rst_j", J_OUT, 0);
    check("rst_clip", ADC_CLIP, 0);
    RST_N = 1'b1;
    tick;

    // Settled window with constant data, then negative floor rounding with S=0
    run_window(4, 2, 1, -1, -1);
    run_window(0, 2, 2, -1, -1);

    // Reset in the middle of an accumulation, with ADC_EN left high
    ADC_EN = 1'b1;
    SETTLE_CYCLES = '0;
    AVG_LOG2 = 4'd3;
    ADC_DATA = 14'sd50;
    repeat (3) tick;
    check("midrst_pre_state", ACQ_STATE, ACQ_ACCUM);
    RST_N = 1'b0;
    tick;
    check("midrst_state", ACQ_STATE, ACQ_IDLE);
    check("midrst_done", ADC_DONE, 0);
    check("midrst_valid", J_VALID, 0);
    check("midrst_j", J_OUT, 0);
    RST_N = 1'b1;
    AVG_LOG2 = 4'd1;
    ADC_DATA = 14'sd7;
    tick;
    check("fresh_state", ACQ_STATE, ACQ_ACCUM);
    tick;
    check("fresh_done_early", ADC_DONE, 0);
    tick;
    check("fresh_done", ADC_DONE, 1);
    check("fresh_valid", J_VALID, 1);
    check("fresh_j", J_OUT, 7);
    ADC_EN = 1'b0;
    tick;
    check("fresh_release", ACQ_STATE, ACQ_IDLE);
    prev_j = 7;
    $display("window after mid-accum reset j=%0d", J_OUT);

    // Random windows
    for (int i = 0; i < 4; i++) begin
      run_window(int'($urandom_range(6, 0)), int'($urandom_range(5, 0)), 0, -1, -1);
    end

    // Abort inside ACCUM, then a complete window with the same settings
    run_window(10, 3, 0, 12, -1);
    run_window(10, 3, 0, -1, -1);

    // Clamped window length with a full-scale sample, then a clean window
    run_window(1, 15, 3, -1, -1);
    run_window(2, 12, 0, -1, -1);

    // Settings changed mid-window apply only from the next window on
    run_window(4, 2, 0, -1, 2);
    run_window(50, 2, 0, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
